pattern_gen_shell: RTL



---
 rtl/pattern_gen_shell_if.sv | 15 +
 rtl/pattern_gen_shell.sv | 95 +++++++++
 2 files changed

// File: rtl/pattern_gen_shell_if.sv
// Control/pattern bundle for pattern_gen_shell: the enable, mode and divider
// inputs plus the registered pattern and tick outputs.
interface pattern_gen_shell_if #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned PRESCALE_W = 4
);
  logic                  EN;
  logic [1:0]            MODE;
  logic [PRESCALE_W-1:0] DIV;
  logic [WIDTH-1:0]      O;
  logic                  TICK;

  modport master (output EN, MODE, DIV, input  O, TICK);
  modport slave  (input  EN, MODE, DIV, output O, TICK);
endinterface

// File: rtl/pattern_gen_shell.sv
// WIDTH-bit pattern generator (binary, Johnson, walking one, LFSR) advanced by a
// programmable prescaler. Define PATGEN_GRAY_EN to make mode 00 emit Gray code.
module pattern_gen_shell #(
  parameter int unsigned      WIDTH      = 6,
  parameter int unsigned      PRESCALE_W = 4,
  parameter logic [WIDTH-1:0] LFSR_TAPS  = WIDTH'(6'b110000)
) (
  input  logic               CLK,
  input  logic               RST,
  pattern_gen_shell_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BIN  = 2'b00,
    MODE_JOHN = 2'b01,
    MODE_WALK = 2'b10,
    MODE_LFSR = 2'b11
  } mode_e;

  mode_e                 mode;
  logic [PRESCALE_W-1:0] cnt_q;
  logic                  tick_int;
  logic                  tick_q;
  logic [WIDTH-1:0]      o_q;
  logic [WIDTH-1:0]      o_next;
  logic                  one_hot;

  assign mode     = mode_e'(bus.MODE);
  // >= rather than == so lowering DIV mid-count ticks on the next enabled cycle
  assign tick_int = bus.EN && (cnt_q >= bus.DIV);
  assign one_hot  = (o_q != '0) && ((o_q & (o_q - WIDTH'(1))) == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (tick_int) begin
      cnt_q <= '0;
    end else if (bus.EN) begin
      cnt_q <= cnt_q + PRESCALE_W'(1);
    end
  end

`ifdef PATGEN_GRAY_EN
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_inc;

  assign bin_inc = bin_q + WIDTH'(1);

  // bin only advances on binary-mode ticks so counting resumes where it left off
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bin_q <= '0;
    end else if (tick_int && (mode == MODE_BIN)) begin
      bin_q <= bin_inc;
    end
  end
`endif

  always_comb begin
    o_next = o_q;
    unique case (mode)
      MODE_BIN: begin
`ifdef PATGEN_GRAY_EN
        o_next = bin_inc ^ (bin_inc >> 1);
`else
        o_next = o_q + WIDTH'(1);
`endif
      end
      MODE_JOHN: o_next = {o_q[WIDTH-2:0], ~o_q[WIDTH-1]};
      MODE_WALK: begin
        if (one_hot) o_next = {o_q[WIDTH-2:0], o_q[WIDTH-1]};
        else         o_next = WIDTH'(1);
      end
      MODE_LFSR: begin
        if (o_q == '0) o_next = WIDTH'(1);
        else           o_next = {o_q[WIDTH-2:0], ^(o_q & LFSR_TAPS)};
      end
      default: o_next = o_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_int;
      if (tick_int) o_q <= o_next;
    end
  end

  assign bus.O    = o_q;
  assign bus.TICK = tick_q;

endmodule
